// File: rtl/rr_arb3_pkg.sv
// Shared types and helpers for the three-client round-robin arbiter.
package rr_arb3_pkg;

    localparam int unsigned NREQ = 3;
    localparam int unsigned IDW  = 2;

    localparam logic [IDW-1:0] GNT_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Successor index modulo three; out-of-range input wraps to client 0.
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] last);
        logic [IDW-1:0] nxt;
        case (last)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    function automatic logic [NREQ-1:0] idx2oh(input logic [IDW-1:0] idx);
        logic [NREQ-1:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin pick: rotate so that (last+1) is slot 0,
// fixed-priority select, then map the slot back to a client index.
module rr_pick3
    import rr_arb3_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [IDW-1:0]  pick_id,
    output logic            pick_vld
);

    logic [IDW-1:0]  base;
    logic [NREQ-1:0] rot;
    logic [NREQ-1:0] sel;

    assign base = next_idx(last);

    always_comb begin
        rot = req;
        case (base)
            2'd1:    rot = {req[0], req[2], req[1]};
            2'd2:    rot = {req[1], req[0], req[2]};
            default: rot = req;
        endcase
    end

    // Fixed-priority network: slot 0 beats slot 1 beats slot 2.
    assign sel[0]   = rot[0];
    assign sel[1]   = ~rot[0] & rot[1];
    assign sel[2]   = ~(rot[0] | rot[1]) & rot[2];
    assign pick_vld = rot[0] | rot[1] | rot[2];

    always_comb begin
        pick_id = GNT_NONE;
        if (sel[0])
            pick_id = base;
        else if (sel[1])
            pick_id = next_idx(base);
        else if (sel[2])
            pick_id = next_idx(next_idx(base));
    end

endmodule

// File: rtl/rr_arb3_ctrl.sv
// Three-requester round-robin arbiter with registered one-hot grant,
// per-tenure hold limit and a mandatory one-cycle gap between grants.
module rr_arb3_ctrl
    import rr_arb3_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CW       = 5
) (
    input  logic            CLK,
    input  logic            RN,
    input  logic [2:0]      req,
    output logic [2:0]      gnt,
    output logic [1:0]      gnt_id,
    output logic            busy,
    output logic            timeout
);

    localparam logic [CW-1:0] MAX_HOLD_C = CW'(MAX_HOLD);
    localparam logic [CW-1:0] CNT_SAT    = {CW{1'b1}};

    state_e          state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [CW-1:0]   hold_q, hold_d;

    logic [NREQ-1:0] gnt_d;
    logic [IDW-1:0]  gnt_id_d;
    logic            busy_d;
    logic            timeout_d;

    logic [IDW-1:0]  pick_id;
    logic            pick_vld;
    logic            req_g;
    logic            hold_lim;

    rr_pick3 u_pick (
        .req      (req),
        .last     (last_q),
        .pick_id  (pick_id),
        .pick_vld (pick_vld)
    );

    assign req_g    = |(gnt & req);
    assign hold_lim = (MAX_HOLD != 0) && (hold_q >= MAX_HOLD_C);

    // State, pointer, counter and output registers.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            last_q  <= 2'd2;
            hold_q  <= '0;
            gnt     <= '0;
            gnt_id  <= GNT_NONE;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            gnt     <= gnt_d;
            gnt_id  <= gnt_id_d;
            busy    <= busy_d;
            timeout <= timeout_d;
        end
    end

    // Next state, last pointer and hold counter.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE, GAP: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    hold_d  = CW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (req_g && !hold_lim) begin
                    hold_d = (hold_q == CNT_SAT) ? hold_q : hold_q + CW'(1);
                end else begin
                    state_d = GAP;
                    last_d  = gnt_id;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        gnt_d     = '0;
        gnt_id_d  = GNT_NONE;
        timeout_d = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (pick_vld) begin
                    gnt_d    = idx2oh(pick_id);
                    gnt_id_d = pick_id;
                end
            end
            GRANT: begin
                if (req_g && !hold_lim) begin
                    gnt_d    = gnt;
                    gnt_id_d = gnt_id;
                end else begin
                    // A still-requesting client losing the grant is a forced release.
                    timeout_d = req_g;
                end
            end
            default: ;
        endcase
        busy_d = (state_d == GRANT);
    end

endmodule

// File: tb/tb_rr_arb3_ctrl.sv
// Directed self-checking bench for rr_arb3_ctrl (MAX_HOLD=4 and MAX_HOLD=3 instances).
module tb_rr_arb3_ctrl;

    logic       CLK;
    logic       RN;
    logic [2:0] req_a, req_b;
    logic [2:0] gnt_a, gnt_b;
    logic [1:0] gnt_id_a, gnt_id_b;
    logic       busy_a, busy_b;
    logic       timeout_a, timeout_b;

    int checks   = 0;
    int failures = 0;

    rr_arb3_ctrl #(.MAX_HOLD(4), .CW(5)) u_dut_a (
        .CLK     (CLK),
        .RN      (RN),
        .req     (req_a),
        .gnt     (gnt_a),
        .gnt_id  (gnt_id_a),
        .busy    (busy_a),
        .timeout (timeout_a)
    );

    rr_arb3_ctrl #(.MAX_HOLD(3), .CW(5)) u_dut_b (
        .CLK     (CLK),
        .RN      (RN),
        .req     (req_b),
        .gnt     (gnt_b),
        .gnt_id  (gnt_id_b),
        .busy    (busy_b),
        .timeout (timeout_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [1:0] oh2id(input logic [2:0] oh);
        case (oh)
            3'b001:  return 2'd0;
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'b11;
        endcase
    endfunction

    // Full-load pattern with MAX_HOLD=4, starting at the first edge after reset.
    logic [2:0] exp_rr [16] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
                                3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
                                3'b100, 3'b100, 3'b100, 3'b100, 3'b000,
                                3'b001};

    initial begin
        RN    = 1'b0;
        req_a = 3'b111;
        req_b = 3'b000;
        tick();
        tick();
        chk("rst_gnt",     32'(gnt_a),     32'(3'b000));
        chk("rst_gnt_id",  32'(gnt_id_a),  32'(2'b11));
        chk("rst_busy",    32'(busy_a),    32'(1'b0));
        chk("rst_timeout", 32'(timeout_a), 32'(1'b0));

        @(negedge CLK);
        RN = 1'b1;

        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("rr_gnt[%0d]", i),     32'(gnt_a),     32'(exp_rr[i]));
            chk($sformatf("rr_gnt_id[%0d]", i),  32'(gnt_id_a),  32'(oh2id(exp_rr[i])));
            chk($sformatf("rr_busy[%0d]", i),    32'(busy_a),    32'(exp_rr[i] != 3'b000));
            chk($sformatf("rr_timeout[%0d]", i), 32'(timeout_a), 32'(exp_rr[i] == 3'b000));
        end

        // Client 0 drops mid-tenure: normal release.
        req_a = 3'b000;
        tick();
        chk("drop_gnt",     32'(gnt_a),     32'(3'b000));
        chk("drop_timeout", 32'(timeout_a), 32'(1'b0));
        tick();

        // Single client 1 for three cycles.
        req_a = 3'b010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("single_gnt[%0d]", i),  32'(gnt_a),     32'(3'b010));
            chk($sformatf("single_busy[%0d]", i), 32'(busy_a),    32'(1'b1));
            chk($sformatf("single_to[%0d]", i),   32'(timeout_a), 32'(1'b0));
        end
        req_a = 3'b000;
        tick();
        chk("single_end_gnt",  32'(gnt_a),     32'(3'b000));
        chk("single_end_busy", 32'(busy_a),    32'(1'b0));
        chk("single_end_to",   32'(timeout_a), 32'(1'b0));

        // Rotation: client 0 takes one cycle, then 101 must go to client 2 first.
        req_a = 3'b001;
        tick();
        chk("rot_c0", 32'(gnt_a), 32'(3'b001));
        req_a = 3'b000;
        tick();
        chk("rot_c0_rel", 32'(gnt_a), 32'(3'b000));
        req_a = 3'b101;
        tick();
        chk("rot_c2",    32'(gnt_a),    32'(3'b100));
        chk("rot_c2_id", 32'(gnt_id_a), 32'(2'd2));
        req_a = 3'b001;
        tick();
        chk("rot_gap",    32'(gnt_a),     32'(3'b000));
        chk("rot_gap_to", 32'(timeout_a), 32'(1'b0));
        tick();
        chk("rot_c0b",    32'(gnt_a),    32'(3'b001));
        chk("rot_c0b_id", 32'(gnt_id_a), 32'(2'd0));

        // Bring client 2 into a grant, then reset asynchronously between edges.
        req_a = 3'b100;
        tick();
        chk("pre_rst_gap", 32'(gnt_a), 32'(3'b000));
        tick();
        chk("pre_rst_gnt", 32'(gnt_a), 32'(3'b100));
        #2;
        RN = 1'b0;
        #1;
        chk("async_gnt",    32'(gnt_a),    32'(3'b000));
        chk("async_gnt_id", 32'(gnt_id_a), 32'(2'b11));
        chk("async_busy",   32'(busy_a),   32'(1'b0));
        req_a = 3'b111;
        req_b = 3'b001;
        @(negedge CLK);
        RN = 1'b1;
        tick();
        chk("post_rst_gnt", 32'(gnt_a), 32'(3'b001));

        // MAX_HOLD=3: request falls in the cycle the count reaches the limit.
        chk("b_gnt1", 32'(gnt_b), 32'(3'b001));
        tick();
        tick();
        chk("b_gnt3", 32'(gnt_b), 32'(3'b001));
        req_b = 3'b000;
        tick();
        chk("b_coinc_gnt", 32'(gnt_b),     32'(3'b000));
        chk("b_coinc_to",  32'(timeout_b), 32'(1'b0));

        // MAX_HOLD=3 sole requester: forced release, then re-grant after the gap.
        req_b = 3'b001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("b_hold[%0d]", i), 32'(gnt_b), 32'(3'b001));
        end
        tick();
        chk("b_to_gnt",  32'(gnt_b),     32'(3'b000));
        chk("b_to_flag", 32'(timeout_b), 32'(1'b1));
        chk("b_to_busy", 32'(busy_b),    32'(1'b0));
        tick();
        chk("b_regrant",    32'(gnt_b),     32'(3'b001));
        chk("b_regrant_to", 32'(timeout_b), 32'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arb3_ctrl.md
Name: rr_arb3_ctrl

Overview:
- Three-requester round-robin arbiter that shares one resource (a bus, port or cell-array slice) between three clients.
- Grants are registered, one-hot, and held until the client drops its request or a hold limit expires.
- A mandatory one-cycle gap separates any two grants (break-before-make).
- The next-requester pick is a small combinational network that maps directly onto 3-input NOR/AND/OR cells of the gp9t3v3 library; state and counter use reset flops.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles per tenure; 0 disables the limit.
- CW, 5: hold-counter width; must satisfy 2^CW > MAX_HOLD.

Ports:
- CLK  input  1  rising-edge clock; the only clock.
- RN  input  1  asynchronous active-low reset.
- req  input  3  request from client i; level-sensitive.
- gnt  output  3  one-hot grant, registered; 000 when no grant.
- gnt_id  output  2  index of granted client; 2'b11 when none.
- busy  output  1  high while any gnt bit is high.
- timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (RN=0, asynchronous):
  - gnt=000, gnt_id=11, busy=0, timeout=0.
  - state=IDLE, hold_cnt=0, last=2, so client 0 has first priority.
  - Outputs clear immediately, including mid-grant.
  - Exit from reset is synchronous to the next CLK edge.
- States: IDLE, GRANT, GAP.
- Priority order: search starts at (last+1) mod 3, then (last+2) mod 3, then last.
- IDLE and GAP both arbitrate:
  - If req != 000 at a rising edge, next state=GRANT.
  - gnt gets the winner's bit, gnt_id=winner, hold_cnt=1.
  - Latency is 1 cycle from req sampled high to gnt high.
  - If req=000, next state=IDLE.
- GRANT, with g = granted index:
  - req[g]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD): stay; hold_cnt+1, saturating at 2^CW-1 when MAX_HOLD=0.
  - req[g]=0: next state=GAP; gnt=000, gnt_id=11, last=g, timeout=0.
  - req[g]=1 and hold_cnt==MAX_HOLD (MAX_HOLD>0): next state=GAP; gnt=000, gnt_id=11, last=g, timeout=1 for exactly that cycle.
  - A tenure therefore lasts at most MAX_HOLD cycles.
- GAP always lasts exactly one cycle with gnt=000. A new grant can appear at the edge that ends GAP.
- The request of a non-granted client may change freely during GRANT; it is ignored until GAP or IDLE.
- A timed-out client drops to lowest priority. If it is the only requester, it is re-granted after the one-cycle gap.
- If req[g] falls in the same cycle hold_cnt reaches MAX_HOLD, this is a normal release: timeout=0.
- timeout is never high while gnt!=000.
- busy equals (state==GRANT). gnt_id always equals the encoding of gnt.
- Invariants: gnt is always one-hot or zero; no two grants are adjacent without a zero cycle between them.

Decomposition:
- Package rr_arb3_pkg:
  - state enum (IDLE=2'd0, GRANT=2'd1, GAP=2'd2);
  - NREQ=3; GNT_NONE=2'b11;
  - function next_idx(last) returning (last+1) mod 3.
- Sub-module rr_pick3: combinational; inputs req[2:0] and last[1:0]; outputs pick_id[1:0] and pick_vld.
  - Written as rotate, then a fixed-priority 3-input NOR/AND/OR network, then un-rotate.
  - Verified standalone, exhaustively over all 24 (req, last) combinations with last in 0..2.
- Top level holds the FSM, the last pointer, hold_cnt and the output registers.

Test Plan:
- Reset: RN=0 with req=111 -> gnt=000, gnt_id=11, busy=0, timeout=0. Release RN; first edge -> gnt=001.
- Round-robin under full load (MAX_HOLD=4, req=111 constant):
  - gnt=001 for 4 cycles, then 000 with timeout=1.
  - Then 010 x4, gap, 100 x4, gap, 001; the pattern repeats.
- Single client: req=010 for 3 cycles starting at edge k -> gnt=010 at edges k+1..k+3, gnt=000 at k+4, busy tracks gnt, timeout stays 0.
- Rotation after a tenure: last=0 after client 0 releases, then req=101 -> next grant is 100; after it releases -> 001.
- Coincident release (MAX_HOLD=3): req[0] falls in the cycle hold_cnt=3 -> gnt=000 next cycle, timeout=0.
- Async reset mid-grant: drive RN low between edges while gnt=100 -> gnt=000 and gnt_id=11 without waiting for CLK; after release, client 0 has priority again.
